lcd_cmd_scheduler: RTL and testbench
====================================

Name: lcd_cmd_scheduler

Overview:
- Sequences the LCD instruction FSM, which serialises one 10-bit {RS,RW,DB[7:0]} word as two nibbles.
- After power-on init completes, it issues the fixed configuration sequence. It then shares the instruction FSM between two requesters: a character-write port and a clear-display port.
- It also owns the 12-bit clk_cnt timebase the instruction FSM compares against.
- It sits between the top-level LCD controller logic and the instruction FSM.

Parameters:
- CLEAR_WAIT, 82000: extra cycles idled after a Clear Display instruction completes (1.64 ms at 50 MHz).
- CNT_W, 17: width of the internal post-clear delay counter; must hold CLEAR_WAIT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init_done  in  1  level; power-on init sequence finished
- instr_enable  in  1  instruction FSM enable output; high while an instruction is in flight
- instr_done  in  1  instruction FSM done; one-cycle pulse
- wr_req  in  1  level; request to write a character
- wr_addr  in  7  DDRAM address for the character
- wr_data  in  8  character code
- clr_req  in  1  level; request to clear the display
- next_instruction  out  1  one-cycle start pulse to the instruction FSM
- db  out  10  {RS,RW,DB[7:0]} to the instruction FSM
- clk_cnt  out  12  timebase to the instruction FSM
- wr_ack  out  1  one-cycle pulse; character write complete
- clr_ack  out  1  one-cycle pulse; clear complete, including CLEAR_WAIT
- cfg_done  out  1  level; configuration sequence complete
- busy  out  1  level; high unless in IDLE with cfg_done=1

Behaviour:
- Reset (async, active-high): all outputs 0, db=10'h000, clk_cnt=0, state=WAIT_INIT, latches and delay counter cleared. Reset mid-instruction abandons it; configuration reruns after init_done.
- All outputs are registered.
- Timebase:
  - clk_cnt <= instr_enable ? clk_cnt+1 : 0.
  - Wraps mod 4096; a wrap is unreachable in legal operation, where max use is 2180.
- States:
  - WAIT_INIT: wait for init_done=1.
  - CFG_ISSUE/CFG_WAIT: cfg_idx steps 0..3 through 0x028 (Function Set), 0x006 (Entry Mode), 0x00C (Display On), 0x001 (Clear).
  - CLR_DELAY: count CLEAR_WAIT cycles.
  - IDLE.
  - ADDR_ISSUE/ADDR_WAIT.
  - DATA_ISSUE/DATA_WAIT.
  - CLR_ISSUE/CLR_WAIT.
- ISSUE state, fixed 1 cycle:
  - Drive db for the command.
  - Assert next_instruction for exactly that cycle.
  - Go to the matching WAIT state.
- WAIT state:
  - db held stable.
  - Leave on the cycle instr_done=1 is sampled.
  - instr_done in any other state is ignored.
- Configuration:
  - After cfg idx 0..2 completes, go to the next CFG_ISSUE.
  - After idx 3 (clear) completes, go to CLR_DELAY.
  - When the delay expires: if the clear was from configuration, set cfg_done=1 and go to IDLE.
- CLR_DELAY:
  - Counter starts at 0 on entry and increments each cycle.
  - Exit when counter==CLEAR_WAIT-1, i.e. exactly CLEAR_WAIT cycles in state.
- IDLE arbitration:
  - Requests are sampled only in IDLE with cfg_done=1.
  - clr_req has priority over wr_req; a simultaneous pair serves the clear first. A write still held is then served on the next IDLE visit.
  - Requests while busy are not queued; the requester holds the level until ack.
- Write:
  - Latch wr_addr/wr_data on acceptance.
  - ADDR_ISSUE db = {2'b00, 1'b1, addr}.
  - Then DATA_ISSUE db = {2'b10, data}.
  - wr_ack is pulsed the cycle after data instr_done is sampled, coincident with return to IDLE.
- Clear:
  - CLR_ISSUE db = 0x001, then CLR_WAIT, then CLR_DELAY.
  - clr_ack is pulsed on the cycle of return to IDLE.
- Back-to-back:
  - A requester may drop req on the ack cycle.
  - If still high in IDLE the cycle after ack, it is served again; the requester must deassert on ack.
- db returns to 10'h000 in IDLE and WAIT_INIT.
- busy=0 only in IDLE with cfg_done=1.

Test Plan:
- Configuration sequence:
  - Stimulus: reset, init_done=1 at cycle 5; instruction FSM model returns instr_done ~2200 cycles after each start; CLEAR_WAIT=100.
  - Response: exactly 4 next_instruction pulses with db = 0x028, 0x006, 0x00C, 0x001. cfg_done rises 100 cycles after the 4th instr_done; busy falls with it.
- Timebase:
  - Stimulus: instr_enable high for 2181 cycles, then low.
  - Response: clk_cnt counts 1..2181, then returns to 0 the cycle after enable drops.
- Character write:
  - Stimulus: wr_req with wr_addr=7'h05, wr_data=8'h41.
  - Response: db=0x085, then db=0x241. wr_ack is one cycle long, the cycle after the second instr_done.
- Simultaneous requests:
  - Stimulus: clr_req and wr_req asserted in the same IDLE cycle.
  - Response: db=0x001 first, clr_ack after CLEAR_WAIT, then the write sequence and wr_ack.
- Busy and stray done:
  - Stimulus: wr_req raised during CLR_DELAY; a stray instr_done pulse in IDLE.
  - Response: write not started until IDLE; stray done has no effect and produces no pulses.
- Mid-write reset:
  - Stimulus: reset asserted during DATA_WAIT.
  - Response: all outputs immediately 0; no wr_ack; configuration reissues after init_done.

Source files
------------

// File: rtl/lcd_cmd_scheduler.sv
// Arbitrates the LCD instruction FSM between the power-on configuration sequence,
// a character-write port and a clear-display port; also owns the clk_cnt timebase.
module lcd_cmd_scheduler #(
    parameter int CLEAR_WAIT = 82000,
    parameter int CNT_W      = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        instr_enable,
    input  logic        instr_done,
    input  logic        wr_req,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clr_req,
    output logic        next_instruction,
    output logic [9:0]  db,
    output logic [11:0] clk_cnt,
    output logic        wr_ack,
    output logic        clr_ack,
    output logic        cfg_done,
    output logic        busy
);

    typedef enum logic [3:0] {
        WAIT_INIT,
        CFG_ISSUE,
        CFG_WAIT,
        CLR_DELAY,
        IDLE,
        ADDR_ISSUE,
        ADDR_WAIT,
        DATA_ISSUE,
        DATA_WAIT,
        CLR_ISSUE,
        CLR_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(CLEAR_WAIT - 1);

    state_t           state, state_n;
    logic [1:0]       cfg_idx, cfg_idx_n;
    logic [CNT_W-1:0] dly_cnt;
    logic [6:0]       addr_q, addr_n;
    logic [7:0]       data_q, data_n;
    logic [9:0]       cfg_word;
    logic [9:0]       db_n;
    logic             next_instr_n;
    logic             wr_ack_n;
    logic             clr_ack_n;
    logic             cfg_done_n;
    logic             busy_n;

    // Next-state logic; requests are ignored during an ack cycle so a requester
    // that drops its level on seeing the ack is not served twice.
    always_comb begin
        state_n    = state;
        cfg_idx_n  = cfg_idx;
        addr_n     = addr_q;
        data_n     = data_q;
        wr_ack_n   = 1'b0;
        clr_ack_n  = 1'b0;
        cfg_done_n = cfg_done;

        case (state)
            WAIT_INIT: begin
                if (init_done) begin
                    cfg_idx_n = 2'd0;
                    state_n   = CFG_ISSUE;
                end
            end
            CFG_ISSUE: state_n = CFG_WAIT;
            CFG_WAIT: begin
                if (instr_done) begin
                    if (cfg_idx == 2'd3) begin
                        state_n = CLR_DELAY;
                    end else begin
                        cfg_idx_n = cfg_idx + 2'd1;
                        state_n   = CFG_ISSUE;
                    end
                end
            end
            CLR_DELAY: begin
                if (dly_cnt == DLY_LAST) begin
                    state_n = IDLE;
                    if (cfg_done) begin
                        clr_ack_n = 1'b1;
                    end else begin
                        cfg_done_n = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (cfg_done && !wr_ack && !clr_ack) begin
                    if (clr_req) begin
                        state_n = CLR_ISSUE;
                    end else if (wr_req) begin
                        addr_n  = wr_addr;
                        data_n  = wr_data;
                        state_n = ADDR_ISSUE;
                    end
                end
            end
            ADDR_ISSUE: state_n = ADDR_WAIT;
            ADDR_WAIT: begin
                if (instr_done) begin
                    state_n = DATA_ISSUE;
                end
            end
            DATA_ISSUE: state_n = DATA_WAIT;
            DATA_WAIT: begin
                if (instr_done) begin
                    state_n  = IDLE;
                    wr_ack_n = 1'b1;
                end
            end
            CLR_ISSUE: state_n = CLR_WAIT;
            CLR_WAIT: begin
                if (instr_done) begin
                    state_n = CLR_DELAY;
                end
            end
            default: state_n = WAIT_INIT;
        endcase
    end

    always_comb begin
        cfg_word = 10'h000;
        case (cfg_idx_n)
            2'd0: cfg_word = 10'h028;
            2'd1: cfg_word = 10'h006;
            2'd2: cfg_word = 10'h00C;
            2'd3: cfg_word = 10'h001;
            default: cfg_word = 10'h000;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        db_n = db;
        case (state_n)
            WAIT_INIT, IDLE:        db_n = 10'h000;
            CFG_ISSUE, CFG_WAIT:    db_n = cfg_word;
            ADDR_ISSUE, ADDR_WAIT:  db_n = {2'b00, 1'b1, addr_n};
            DATA_ISSUE, DATA_WAIT:  db_n = {2'b10, data_n};
            CLR_ISSUE, CLR_WAIT:    db_n = 10'h001;
            default:                db_n = db;
        endcase
        next_instr_n = (state_n == CFG_ISSUE) || (state_n == ADDR_ISSUE) ||
                       (state_n == DATA_ISSUE) || (state_n == CLR_ISSUE);
        busy_n       = !((state_n == IDLE) && cfg_done_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= WAIT_INIT;
            cfg_idx          <= 2'd0;
            addr_q           <= 7'h00;
            data_q           <= 8'h00;
            next_instruction <= 1'b0;
            db               <= 10'h000;
            wr_ack           <= 1'b0;
            clr_ack          <= 1'b0;
            cfg_done         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_n;
            cfg_idx          <= cfg_idx_n;
            addr_q           <= addr_n;
            data_q           <= data_n;
            next_instruction <= next_instr_n;
            db               <= db_n;
            wr_ack           <= wr_ack_n;
            clr_ack          <= clr_ack_n;
            cfg_done         <= cfg_done_n;
            busy             <= busy_n;
        end
    end

    // Post-clear delay: zero on entry, so exit at DLY_LAST gives CLEAR_WAIT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_cnt <= '0;
        end else if (state == CLR_DELAY) begin
            dly_cnt <= dly_cnt + 1'b1;
        end else begin
            dly_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt <= 12'd0;
        end else if (instr_enable) begin
            clk_cnt <= clk_cnt + 12'd1;
        end else begin
            clk_cnt <= 12'd0;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench for lcd_cmd_scheduler: a small instruction-FSM model answers each
// start pulse, and a monitor logs issued words, done pulses and acks per cycle.
module tb_lcd_cmd_scheduler;

    localparam int CW = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        instr_enable;
    logic        instr_done;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        clr_req;
    logic        next_instruction;
    logic [9:0]  db;
    logic [11:0] clk_cnt;
    logic        wr_ack;
    logic        clr_ack;
    logic        cfg_done;
    logic        busy;

    logic model_enable = 1'b0;
    logic model_done   = 1'b0;
    logic tb_enable    = 1'b0;
    logic tb_done      = 1'b0;
    int   model_len    = 2200;

    int checks   = 0;
    int failures = 0;

    int       cyc = 0;
    int       pulse_cnt = 0;
    logic [9:0] pulse_db [0:63];
    int       done_cyc = 0;
    int       cfg_rise_cyc = 0;
    int       wr_ack_cnt = 0;
    int       clr_ack_cnt = 0;
    int       wr_ack_cyc = 0;
    int       clr_ack_cyc = 0;
    logic     prev_cfg = 1'b0;

    assign instr_enable = model_enable | tb_enable;
    assign instr_done   = model_done | tb_done;

    always #5 clk = ~clk;

    lcd_cmd_scheduler #(.CLEAR_WAIT(CW), .CNT_W(17)) dut (
        .clk              (clk),
        .reset            (reset),
        .init_done        (init_done),
        .instr_enable     (instr_enable),
        .instr_done       (instr_done),
        .wr_req           (wr_req),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .clr_req          (clr_req),
        .next_instruction (next_instruction),
        .db               (db),
        .clk_cnt          (clk_cnt),
        .wr_ack           (wr_ack),
        .clr_ack          (clr_ack),
        .cfg_done         (cfg_done),
        .busy             (busy)
    );

    // Instruction FSM model: enable for model_len cycles, done on the last one;
    // abandons the instruction if reset is seen.
    initial begin
        forever begin
            if (next_instruction === 1'b1 && reset === 1'b0) begin
                model_enable = 1'b1;
                for (int k = 1; k < model_len && reset === 1'b0; k++) begin
                    @(negedge clk);
                end
                if (reset === 1'b0) begin
                    model_done = 1'b1;
                    @(negedge clk);
                end
                model_done   = 1'b0;
                model_enable = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor sampled just after each rising edge; cyc numbers the edges.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (next_instruction === 1'b1) begin
            pulse_db[pulse_cnt % 64] = db;
            pulse_cnt = pulse_cnt + 1;
        end
        if (instr_done === 1'b1) done_cyc = cyc;
        if (cfg_done === 1'b1 && prev_cfg === 1'b0) cfg_rise_cyc = cyc;
        prev_cfg = cfg_done;
        if (wr_ack === 1'b1) begin
            wr_ack_cnt = wr_ack_cnt + 1;
            wr_ack_cyc = cyc;
        end
        if (clr_ack === 1'b1) begin
            clr_ack_cnt = clr_ack_cnt + 1;
            clr_ack_cyc = cyc;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_wr_ack(input string tag);
        int n = 0;
        while (wr_ack !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'd0, wr_ack}, 32'd1);
    endtask

    task automatic wait_clr_ack(input string tag);
        int n = 0;
        while (clr_ack !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'd0, clr_ack}, 32'd1);
    endtask

    task automatic wait_cfg_done(input string tag);
        int n = 0;
        while (cfg_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, {31'd0, cfg_done}, 32'd1);
    endtask

    task automatic wait_pulses(input int target, input string tag);
        int n = 0;
        while (pulse_cnt < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, pulse_cnt, target);
    endtask

    task automatic check_cfg_words(input int base, input string tag);
        check_output({tag, "_w0"}, {22'd0, pulse_db[base % 64]}, 32'h028);
        check_output({tag, "_w1"}, {22'd0, pulse_db[(base + 1) % 64]}, 32'h006);
        check_output({tag, "_w2"}, {22'd0, pulse_db[(base + 2) % 64]}, 32'h00C);
        check_output({tag, "_w3"}, {22'd0, pulse_db[(base + 3) % 64]}, 32'h001);
    endtask

    int base;
    int wr_base;
    int clr_base;

    initial begin
        reset     = 1'b1;
        init_done = 1'b0;
        wr_req    = 1'b0;
        clr_req   = 1'b0;
        wr_addr   = 7'h00;
        wr_data   = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_next", {31'd0, next_instruction}, 32'd0);
        check_output("rst_db", {22'd0, db}, 32'h000);
        check_output("rst_clk_cnt", {20'd0, clk_cnt}, 32'd0);
        check_output("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        check_output("rst_clr_ack", {31'd0, clr_ack}, 32'd0);
        check_output("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);

        // Configuration sequence, init_done at cycle 5
        reset = 1'b0;
        base  = pulse_cnt;
        repeat (3) @(negedge clk);
        init_done = 1'b1;
        repeat (3) @(negedge clk);
        check_output("cfg_busy_high", {31'd0, busy}, 32'd1);
        wait_cfg_done("cfg_done_timeout");
        check_output("cfg_pulse_count", pulse_cnt - base, 32'd4);
        check_cfg_words(base, "cfg");
        check_output("cfg_delay", cfg_rise_cyc - done_cyc, CW);
        check_output("cfg_busy_low", {31'd0, busy}, 32'd0);
        check_output("cfg_idle_db", {22'd0, db}, 32'h000);

        // Timebase driven directly while idle
        model_len = 30;
        tb_enable = 1'b1;
        @(negedge clk);
        check_output("tb_cnt_first", {20'd0, clk_cnt}, 32'd1);
        repeat (2180) @(negedge clk);
        check_output("tb_cnt_last", {20'd0, clk_cnt}, 32'd2181);
        tb_enable = 1'b0;
        @(negedge clk);
        check_output("tb_cnt_clear", {20'd0, clk_cnt}, 32'd0);

        // Character write
        base    = pulse_cnt;
        wr_base = wr_ack_cnt;
        wr_addr = 7'h05;
        wr_data = 8'h41;
        wr_req  = 1'b1;
        wait_wr_ack("wr_ack_timeout");
        wr_req = 1'b0;
        check_output("wr_pulse_count", pulse_cnt - base, 32'd2);
        check_output("wr_addr_word", {22'd0, pulse_db[base % 64]}, 32'h085);
        check_output("wr_data_word", {22'd0, pulse_db[(base + 1) % 64]}, 32'h241);
        // ack registers at the same edge that samples done
        check_output("wr_ack_timing", wr_ack_cyc - done_cyc, 32'd0);
        @(negedge clk);
        check_output("wr_ack_one_cycle", {31'd0, wr_ack}, 32'd0);
        check_output("wr_ack_count", wr_ack_cnt - wr_base, 32'd1);
        check_output("wr_idle_busy", {31'd0, busy}, 32'd0);
        check_output("wr_idle_db", {22'd0, db}, 32'h000);

        // Simultaneous clear and write: clear first
        base     = pulse_cnt;
        wr_base  = wr_ack_cnt;
        clr_base = clr_ack_cnt;
        wr_addr  = 7'h12;
        wr_data  = 8'h5A;
        wr_req   = 1'b1;
        clr_req  = 1'b1;
        wait_clr_ack("sim_clr_timeout");
        clr_req = 1'b0;
        check_output("sim_clr_delay", clr_ack_cyc - done_cyc, CW);
        check_output("sim_clr_only", pulse_cnt - base, 32'd1);
        check_output("sim_clr_word", {22'd0, pulse_db[base % 64]}, 32'h001);
        check_output("sim_no_wr_ack_yet", wr_ack_cnt - wr_base, 32'd0);
        wait_wr_ack("sim_wr_timeout");
        wr_req = 1'b0;
        check_output("sim_pulse_count", pulse_cnt - base, 32'd3);
        check_output("sim_addr_word", {22'd0, pulse_db[(base + 1) % 64]}, 32'h092);
        check_output("sim_data_word", {22'd0, pulse_db[(base + 2) % 64]}, 32'h25A);
        repeat (5) @(negedge clk);
        check_output("sim_clr_ack_count", clr_ack_cnt - clr_base, 32'd1);
        check_output("sim_wr_ack_count", wr_ack_cnt - wr_base, 32'd1);
        check_output("sim_no_reissue", pulse_cnt - base, 32'd3);

        // Write raised during CLR_DELAY waits for IDLE
        base    = pulse_cnt;
        clr_req = 1'b1;
        repeat (60) @(negedge clk);
        wr_addr = 7'h7F;
        wr_data = 8'hFF;
        wr_req  = 1'b1;
        @(negedge clk);
        check_output("bsy_busy", {31'd0, busy}, 32'd1);
        check_output("bsy_not_started", pulse_cnt - base, 32'd1);
        wait_clr_ack("bsy_clr_timeout");
        clr_req = 1'b0;
        check_output("bsy_still_waiting", pulse_cnt - base, 32'd1);
        wait_wr_ack("bsy_wr_timeout");
        wr_req = 1'b0;
        check_output("bsy_addr_word", {22'd0, pulse_db[(base + 1) % 64]}, 32'h0FF);
        check_output("bsy_data_word", {22'd0, pulse_db[(base + 2) % 64]}, 32'h2FF);

        // Stray done in IDLE
        repeat (3) @(negedge clk);
        base     = pulse_cnt;
        wr_base  = wr_ack_cnt;
        clr_base = clr_ack_cnt;
        tb_done  = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (10) @(negedge clk);
        check_output("stray_no_pulse", pulse_cnt - base, 32'd0);
        check_output("stray_no_ack", (wr_ack_cnt - wr_base) + (clr_ack_cnt - clr_base), 32'd0);
        check_output("stray_busy", {31'd0, busy}, 32'd0);
        check_output("stray_db", {22'd0, db}, 32'h000);

        // Reset during DATA_WAIT
        base    = pulse_cnt;
        wr_base = wr_ack_cnt;
        wr_addr = 7'h33;
        wr_data = 8'h77;
        wr_req  = 1'b1;
        wait_pulses(base + 2, "mid_data_issue_timeout");
        repeat (5) @(negedge clk);
        reset  = 1'b1;
        wr_req = 1'b0;
        #1;
        check_output("mid_rst_next", {31'd0, next_instruction}, 32'd0);
        check_output("mid_rst_db", {22'd0, db}, 32'h000);
        check_output("mid_rst_clk_cnt", {20'd0, clk_cnt}, 32'd0);
        check_output("mid_rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base  = pulse_cnt;
        wait_cfg_done("mid_recfg_timeout");
        check_output("mid_recfg_count", pulse_cnt - base, 32'd4);
        check_cfg_words(base, "mid_recfg");
        check_output("mid_no_wr_ack", wr_ack_cnt - wr_base, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
